// File: rtl/writeback_unit_pkg.sv
// Shared types for the register-file writeback path.
package writeback_unit_pkg;
    typedef logic [31:0] word_t;
    typedef logic [4:0]  regid_t;

    typedef struct packed {
        regid_t rd;
        word_t  data;
    } wb_req_t;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_ALU,
        SRC_MEM
    } wb_src_e;
endpackage

// File: rtl/writeback_unit_fifo.sv
// Memory-result FIFO; pointers carry one extra wrap bit to tell full from empty.
module wb_fifo
    import writeback_unit_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  wb_req_t                  din,
    output wb_req_t                  dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    wb_req_t     mem [DEPTH];

    assign count = wr_ptr - rd_ptr;
    assign full  = (count == DEPTH_C);
    assign empty = (wr_ptr == rd_ptr);
    assign dout  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push && !full)
            mem[wr_ptr[AW-1:0]] <= din;
    end
endmodule

// File: rtl/writeback_unit.sv
// Merges ALU and buffered memory results into one registered regfile write per cycle,
// with a starvation guard for the memory path and a busy scoreboard for issue logic.
module writeback_unit
    import writeback_unit_pkg::*;
#(
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned STARVE_LIMIT = 3,
    parameter bit          ZERO_RO      = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     alu_valid,
    output logic                     alu_ready,
    input  regid_t                   alu_rd,
    input  word_t                    alu_data,
    input  logic                     mem_valid,
    output logic                     mem_ready,
    input  regid_t                   mem_rd,
    input  word_t                    mem_data,
    input  logic                     mark_valid,
    input  regid_t                   mark_rd,
    input  regid_t                   q1_addr,
    input  regid_t                   q2_addr,
    output logic                     q1_busy,
    output logic                     q2_busy,
    output logic                     w_enable,
    output regid_t                   w_addr,
    output word_t                    w_data,
    output logic [$clog2(DEPTH):0]   fifo_count
);
    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    logic          fifo_full;
    logic          fifo_empty;
    logic          push;
    logic          pop;
    logic          force_mem;
    wb_req_t       head;
    wb_req_t       sel_req;
    wb_src_e       sel;
    logic [SW-1:0] starve;
    logic [31:0]   busy;

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   ('{rd: mem_rd, data: mem_data}),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Full FIFO refuses pushes even when it pops the same cycle.
    assign mem_ready = !rst && !fifo_full;
    assign push      = mem_valid && mem_ready;
    assign force_mem = !fifo_empty && (starve == STARVE_MAX);
    assign alu_ready = !rst && !force_mem;
    assign pop       = (sel == SRC_MEM);
    assign q1_busy   = busy[q1_addr];
    assign q2_busy   = busy[q2_addr];

    always_comb begin
        sel     = SRC_NONE;
        sel_req = head;
        if (alu_valid && alu_ready) begin
            sel     = SRC_ALU;
            sel_req = '{rd: alu_rd, data: alu_data};
        end else if (!rst && !fifo_empty) begin
            sel = SRC_MEM;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_enable <= 1'b0;
            w_addr   <= '0;
            w_data   <= '0;
            starve   <= '0;
            busy     <= '0;
        end else begin
            w_enable <= (sel != SRC_NONE) && !(ZERO_RO && sel_req.rd == '0);
            if (sel != SRC_NONE) begin
                w_addr <= sel_req.rd;
                w_data <= sel_req.data;
            end
            if (fifo_empty || pop)
                starve <= '0;
            else if (sel == SRC_ALU && starve != STARVE_MAX)
                starve <= starve + 1'b1;
            // Clear lands with the write on w_*; a later set to the same reg overrides it.
            if (pop && !(ZERO_RO && head.rd == '0))
                busy[head.rd] <= 1'b0;
            if (mark_valid && !(ZERO_RO && mark_rd == '0))
                busy[mark_rd] <= 1'b1;
        end
    end
endmodule

// File: tb/tb_writeback_unit.sv
// Self-checking bench for writeback_unit against a queue-based reference model.
module tb_writeback_unit;
    import writeback_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid, alu_ready, mem_valid, mem_ready, mark_valid;
    logic [4:0]  alu_rd, mem_rd, mark_rd, q1_addr, q2_addr, w_addr;
    logic [31:0] alu_data, mem_data, w_data;
    logic        q1_busy, q2_busy, w_enable;
    logic [2:0]  fifo_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    writeback_unit #(.DEPTH(4), .STARVE_LIMIT(3), .ZERO_RO(1'b1)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
        .mark_valid(mark_valid), .mark_rd(mark_rd),
        .q1_addr(q1_addr), .q2_addr(q2_addr), .q1_busy(q1_busy), .q2_busy(q2_busy),
        .w_enable(w_enable), .w_addr(w_addr), .w_data(w_data), .fifo_count(fifo_count)
    );

    // Reference model: a queue of pending memory results plus plain counters.
    typedef struct { logic [4:0] rd; logic [31:0] data; } ent_t;
    ent_t        mq[$];
    int          m_starve;
    bit   [31:0] m_busy;
    bit          m_wen, m_last_mem;
    logic [4:0]  m_waddr;
    logic [31:0] m_wdata;

    function automatic bit m_alu_ready();
        return !rst && !(mq.size() > 0 && m_starve == 3);
    endfunction

    function automatic bit m_mem_ready();
        return !rst && mq.size() < 4;
    endfunction

    task automatic model_step();
        bit   awin, popq, pushq;
        int   size0;
        ent_t h;
        if (rst) begin
            mq.delete(); m_starve = 0; m_busy = '0;
            m_wen = 0; m_waddr = '0; m_wdata = '0; m_last_mem = 0;
            return;
        end
        size0 = mq.size();
        awin  = alu_valid && m_alu_ready();
        popq  = !awin && size0 > 0;
        pushq = mem_valid && m_mem_ready();
        m_last_mem = popq;
        if (awin) begin
            m_wen = (alu_rd != 0); m_waddr = alu_rd; m_wdata = alu_data;
        end else if (popq) begin
            h = mq.pop_front();
            m_wen = (h.rd != 0); m_waddr = h.rd; m_wdata = h.data;
            if (h.rd != 0) m_busy[h.rd] = 1'b0;
        end else begin
            m_wen = 0;
        end
        if (size0 == 0 || popq) m_starve = 0;
        else if (awin && m_starve < 3) m_starve = m_starve + 1;
        if (mark_valid && mark_rd != 0) m_busy[mark_rd] = 1'b1;
        if (pushq) mq.push_back('{mem_rd, mem_data});
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alu_valid = 0; alu_rd = '0; alu_data = '0;
        mem_valid = 0; mem_rd = '0; mem_data = '0;
        mark_valid = 0; mark_rd = '0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1; tick();
        rst = 0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1; mem_valid = 1; mem_rd = 5'd4; mem_data = 32'h1234; q1_addr = 5'd7; q2_addr = 5'd0;
        #1;
        n_checks++; if (mem_ready !== 1'b0) begin n_fail++; $display("FAIL reset_mem_ready: got %b want 0", mem_ready); end
        n_checks++; if (alu_ready !== 1'b0) begin n_fail++; $display("FAIL reset_alu_ready: got %b want 0", alu_ready); end
        tick(); tick();
        n_checks++; if (w_enable !== 1'b0) begin n_fail++; $display("FAIL reset_w_enable: got %b want 0", w_enable); end
        n_checks++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
        n_checks++; if (q1_busy !== 1'b0) begin n_fail++; $display("FAIL reset_q1_busy: got %b want 0", q1_busy); end
        idle(); rst = 0;
    endtask

    task automatic test_alu_only();
        alu_valid = 1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
        tick();
        n_checks++; if (w_enable !== 1'b1 || w_addr !== 5'd5 || w_data !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL alu_write: got en=%b addr=%0d data=%h want en=1 addr=5 data=deadbeef", w_enable, w_addr, w_data);
        end
        alu_rd = 5'd0; alu_data = 32'h5555AAAA;
        tick();
        n_checks++; if (w_enable !== 1'b0) begin n_fail++; $display("FAIL alu_rd0: got en=%b want 0", w_enable); end
        idle(); tick();
        n_checks++; if (w_enable !== 1'b0) begin n_fail++; $display("FAIL alu_idle: got en=%b want 0", w_enable); end
    endtask

    task automatic test_fifo_fill();
        logic [4:0] order[$];
        int pushed = 0, lost = 0, cyc = 0;
        do_reset();
        alu_valid = 1;
        while ((pushed < 5 || mq.size() > 0 || order.size() > 0) && cyc < 60) begin
            alu_rd = 5'd20 + 5'($urandom_range(0, 7)); alu_data = $urandom;
            mem_valid = (pushed < 5); mem_rd = 5'd10 + 5'(pushed); mem_data = $urandom;
            #1;
            n_checks++; if (mem_ready !== m_mem_ready()) begin n_fail++; $display("FAIL fill_mem_ready: got %b want %b", mem_ready, m_mem_ready()); end
            n_checks++; if (alu_ready !== m_alu_ready()) begin n_fail++; $display("FAIL fill_alu_ready: got %b want %b", alu_ready, m_alu_ready()); end
            if (mq.size() > 0) lost = (alu_ready === 1'b1) ? lost + 1 : 0;
            else lost = 0;
            n_checks++; if (lost > 3) begin n_fail++; $display("FAIL fill_head_wait: got %0d losses want <=3", lost); end
            if (mem_valid && m_mem_ready()) begin order.push_back(mem_rd); pushed++; end
            tick(); cyc++;
            if (m_last_mem) begin
                n_checks++; if (w_enable !== 1'b1 || w_addr !== order[0] || w_data !== m_wdata) begin
                    n_fail++; $display("FAIL fill_order: got en=%b addr=%0d data=%h want en=1 addr=%0d data=%h", w_enable, w_addr, w_data, order[0], m_wdata);
                end
                void'(order.pop_front());
            end
            n_checks++; if (fifo_count !== 3'(mq.size())) begin n_fail++; $display("FAIL fill_count: got %0d want %0d", fifo_count, mq.size()); end
        end
        n_checks++; if (cyc >= 60) begin n_fail++; $display("FAIL fill_timeout: got %0d cycles want <60", cyc); end
        idle();
    endtask

    task automatic test_starvation();
        do_reset();
        alu_valid = 1; alu_rd = 5'd3; alu_data = 32'hA;
        mem_valid = 1; mem_rd = 5'd9; mem_data = 32'hCAFE0009;
        tick();
        mem_valid = 0;
        for (int k = 0; k < 4; k++) begin
            n_checks++; if (alu_ready !== (k < 3)) begin n_fail++; $display("FAIL starve_alu_ready%0d: got %b want %b", k, alu_ready, (k < 3)); end
            tick();
        end
        n_checks++; if (w_enable !== 1'b1 || w_addr !== 5'd9 || w_data !== 32'hCAFE0009) begin
            n_fail++; $display("FAIL starve_mem_write: got en=%b addr=%0d data=%h want en=1 addr=9 data=cafe0009", w_enable, w_addr, w_data);
        end
        idle(); tick();
    endtask

    task automatic test_scoreboard();
        do_reset();
        q1_addr = 5'd7; q2_addr = 5'd0;
        mark_valid = 1; mark_rd = 5'd0; tick();
        n_checks++; if (q2_busy !== 1'b0) begin n_fail++; $display("FAIL sb_reg0: got %b want 0", q2_busy); end
        mark_rd = 5'd7; tick(); mark_valid = 0;
        n_checks++; if (q1_busy !== 1'b1) begin n_fail++; $display("FAIL sb_mark: got %b want 1", q1_busy); end
        mem_valid = 1; mem_rd = 5'd7; mem_data = 32'h77; tick(); mem_valid = 0;
        n_checks++; if (q1_busy !== 1'b1) begin n_fail++; $display("FAIL sb_pending: got %b want 1", q1_busy); end
        tick();
        n_checks++; if (w_enable !== 1'b1 || w_addr !== 5'd7 || q1_busy !== 1'b0) begin
            n_fail++; $display("FAIL sb_clear: got en=%b addr=%0d busy=%b want en=1 addr=7 busy=0", w_enable, w_addr, q1_busy);
        end
        mark_valid = 1; tick(); mark_valid = 0;
        mem_valid = 1; mem_data = 32'h78; tick(); mem_valid = 0;
        mark_valid = 1; mark_rd = 5'd7; tick(); mark_valid = 0;
        n_checks++; if (w_enable !== 1'b1 || w_addr !== 5'd7 || q1_busy !== 1'b1) begin
            n_fail++; $display("FAIL sb_set_wins: got en=%b addr=%0d busy=%b want en=1 addr=7 busy=1", w_enable, w_addr, q1_busy);
        end
        alu_valid = 1; alu_rd = 5'd7; alu_data = 32'h99; tick(); alu_valid = 0;
        n_checks++; if (w_enable !== 1'b1 || w_addr !== 5'd7 || q1_busy !== 1'b1) begin
            n_fail++; $display("FAIL sb_alu_no_clear: got en=%b addr=%0d busy=%b want en=1 addr=7 busy=1", w_enable, w_addr, q1_busy);
        end
        idle();
    endtask

    task automatic test_reset_mid();
        do_reset();
        alu_valid = 1; alu_rd = 5'd2;
        for (int i = 0; i < 3; i++) begin
            mem_valid = 1; mem_rd = 5'd12 + 5'(i); mem_data = $urandom; tick();
        end
        idle();
        n_checks++; if (fifo_count !== 3'd3) begin n_fail++; $display("FAIL mid_buffered: got %0d want 3", fifo_count); end
        rst = 1; tick();
        n_checks++; if (fifo_count !== 3'd0 || w_enable !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset: got count=%0d en=%b want count=0 en=0", fifo_count, w_enable);
        end
        rst = 0; tick();
        n_checks++; if (w_enable !== 1'b0 || fifo_count !== 3'd0) begin
            n_fail++; $display("FAIL mid_stale: got en=%b count=%0d want en=0 count=0", w_enable, fifo_count);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            alu_valid  = ($urandom_range(0, 2) != 0); alu_rd = 5'($urandom_range(0, 7)); alu_data = $urandom;
            mem_valid  = $urandom_range(0, 1);        mem_rd = 5'($urandom_range(0, 7)); mem_data = $urandom;
            mark_valid = ($urandom_range(0, 3) == 0); mark_rd = 5'($urandom_range(0, 7));
            q1_addr = 5'($urandom_range(0, 7)); q2_addr = 5'($urandom_range(0, 7));
            #1;
            n_checks++; if (alu_ready !== m_alu_ready() || mem_ready !== m_mem_ready()) begin
                n_fail++; $display("FAIL rnd_ready: got alu=%b mem=%b want alu=%b mem=%b", alu_ready, mem_ready, m_alu_ready(), m_mem_ready());
            end
            tick();
            n_checks++; if (w_enable !== m_wen || (m_wen && (w_addr !== m_waddr || w_data !== m_wdata))) begin
                n_fail++; $display("FAIL rnd_write: got en=%b addr=%0d data=%h want en=%b addr=%0d data=%h", w_enable, w_addr, w_data, m_wen, m_waddr, m_wdata);
            end
            n_checks++; if (fifo_count !== 3'(mq.size()) || q1_busy !== m_busy[q1_addr] || q2_busy !== m_busy[q2_addr]) begin
                n_fail++; $display("FAIL rnd_state: got count=%0d b1=%b b2=%b want count=%0d b1=%b b2=%b", fifo_count, q1_busy, q2_busy, mq.size(), m_busy[q1_addr], m_busy[q2_addr]);
            end
        end
        idle();
    endtask

    initial begin
        idle();
        rst = 1; q1_addr = '0; q2_addr = '0;
        test_reset();
        test_alu_only();
        test_fifo_fill();
        test_starvation();
        test_scoreboard();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
